// File: rtl/branch_perf_monitor.sv
`default_nettype none
// ============================================================================
// branch_perf_monitor: in-order DCACHE write checker against a golden table,
// with run/stall/per-type flush counters, finish and hardware timeout.
// Revision: 1.0
// ============================================================================
module branch_perf_monitor #(
  parameter int N_CHECK     = 16,
  parameter int IDXW        = 4,
  parameter int NUM_TYPES   = 2,
  parameter int TYPEW       = 1,
  parameter int CNTW        = 16,
  parameter int ERRW        = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [IDXW-1:0]           cfg_idx,
  input  logic [29:0]               cfg_addr,
  input  logic [31:0]               cfg_data,
  input  logic                      start,
  input  logic                      flush,
  input  logic                      stall,
  input  logic [TYPEW-1:0]          br_type,
  input  logic                      wen,
  input  logic [29:0]               addr,
  input  logic [31:0]               data,
  output logic [ERRW-1:0]           error_num,
  output logic [CNTW-1:0]           duration,
  output logic [NUM_TYPES*CNTW-1:0] flush_cnt,
  output logic [CNTW-1:0]           stall_cnt,
  output logic [1:0]                state,
  output logic                      finish,
  output logic                      timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam logic [IDXW:0]   LAST_IDX = (IDXW+1)'(N_CHECK - 1);
  localparam logic [CNTW-1:0] TO_LAST  = CNTW'(TIMEOUT_CYC - 1);

  state_t          cur_state;
  logic [IDXW:0]   ptr;
  logic [61:0]     golden [N_CHECK];
  logic [CNTW-1:0] flush_arr [NUM_TYPES];

  logic cfg_ok;
  logic cmp_fire;
  logic last_cmp;
  logic mismatch;

  assign cfg_ok   = (cur_state == S_IDLE) && cfg_we && (32'(cfg_idx) < 32'(N_CHECK));
  assign cmp_fire = (cur_state == S_RUN) && !stall && wen;
  assign last_cmp = cmp_fire && (ptr == LAST_IDX);
  assign mismatch = ({addr, data} != golden[ptr[IDXW-1:0]]);
  assign state    = cur_state;

  genvar gk;
  generate
    for (gk = 0; gk < NUM_TYPES; gk++) begin : g_flush_out
      assign flush_cnt[gk*CNTW +: CNTW] = flush_arr[gk];
    end
  endgenerate

  // Golden contents deliberately survive reset so a rerun needs no reload.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      golden[cfg_idx] <= {cfg_addr, cfg_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
      ptr       <= '0;
      error_num <= '0;
      duration  <= '0;
      stall_cnt <= '0;
      finish    <= 1'b0;
      timeout   <= 1'b0;
      for (int k = 0; k < NUM_TYPES; k++) begin
        flush_arr[k] <= '0;
      end
    end else begin
      case (cur_state)
        S_IDLE: begin
          if (start && !cfg_we) begin
            cur_state <= S_RUN;
            ptr       <= '0;
            error_num <= '0;
            duration  <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < NUM_TYPES; k++) begin
              flush_arr[k] <= '0;
            end
          end
        end
        S_RUN: begin
          if (!(&duration)) begin
            duration <= duration + CNTW'(1);
          end
          // A stalled write is not committed, so it is neither compared nor counted.
          if (stall) begin
            if (!(&stall_cnt)) begin
              stall_cnt <= stall_cnt + CNTW'(1);
            end
          end else begin
            if (flush) begin
              for (int k = 0; k < NUM_TYPES; k++) begin
                if ((br_type == TYPEW'(k)) && !(&flush_arr[k])) begin
                  flush_arr[k] <= flush_arr[k] + CNTW'(1);
                end
              end
            end
            if (wen) begin
              if (mismatch && !(&error_num)) begin
                error_num <= error_num + ERRW'(1);
              end
              ptr <= ptr + (IDXW+1)'(1);
            end
          end
          if (last_cmp) begin
            cur_state <= S_DONE;
            finish    <= 1'b1;
          end else if (duration == TO_LAST) begin
            cur_state <= S_TIMEOUT;
            finish    <= 1'b1;
            timeout   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_perf_monitor.sv
`default_nettype none
// ============================================================================
// tb_branch_perf_monitor: directed stimulus with a queue-based scoreboard.
// Revision: 1.0
// ============================================================================
module tb_branch_perf_monitor;

  localparam int N_CHECK     = 4;
  localparam int IDXW        = 2;
  localparam int NUM_TYPES   = 2;
  localparam int TYPEW       = 1;
  localparam int CNTW        = 16;
  localparam int ERRW        = 8;
  localparam int TIMEOUT_CYC = 20;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_TMO  = 2'd3;

  typedef struct packed {
    logic [7:0]  tag;
    logic [1:0]  st;
    logic [7:0]  err;
    logic [15:0] dur;
    logic [15:0] f0;
    logic [15:0] f1;
    logic [15:0] sc;
    logic        fin;
    logic        tmo;
  } exp_t;

  logic                      clk;
  logic                      rst_n;
  logic                      cfg_we;
  logic [IDXW-1:0]           cfg_idx;
  logic [29:0]               cfg_addr;
  logic [31:0]               cfg_data;
  logic                      start;
  logic                      flush;
  logic                      stall;
  logic [TYPEW-1:0]          br_type;
  logic                      wen;
  logic [29:0]               addr;
  logic [31:0]               data;
  logic [ERRW-1:0]           error_num;
  logic [CNTW-1:0]           duration;
  logic [NUM_TYPES*CNTW-1:0] flush_cnt;
  logic [CNTW-1:0]           stall_cnt;
  logic [1:0]                state;
  logic                      finish;
  logic                      timeout;

  exp_t exp_q[$];
  logic probe;
  logic fin_prev;
  int   checks;
  int   errors;

  branch_perf_monitor #(
    .N_CHECK(N_CHECK), .IDXW(IDXW), .NUM_TYPES(NUM_TYPES), .TYPEW(TYPEW),
    .CNTW(CNTW), .ERRW(ERRW), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .flush(flush),
    .stall(stall), .br_type(br_type), .wen(wen), .addr(addr), .data(data),
    .error_num(error_num), .duration(duration), .flush_cnt(flush_cnt),
    .stall_cnt(stall_cnt), .state(state), .finish(finish), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input int tag, input logic [1:0] s, input int err,
                              input int dur, input int f0, input int f1,
                              input int sc, input logic fin, input logic tmo);
    exp_t e;
    e.tag = 8'(tag);
    e.st  = s;
    e.err = 8'(err);
    e.dur = 16'(dur);
    e.f0  = 16'(f0);
    e.f1  = 16'(f1);
    e.sc  = 16'(sc);
    e.fin = fin;
    e.tmo = tmo;
    return e;
  endfunction

  task automatic check(input int tag, input string nm, input logic [31:0] got,
                       input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL t%0d %s got %0d expected %0d", tag, nm, got, expv);
    end
  endtask

  // Monitor: pops an expectation when finish rises or the stimulus requests a probe.
  initial begin
    exp_t e;
    logic fire;
    fin_prev = 1'b0;
    forever begin
      @(negedge clk);
      fire = (probe === 1'b1) || (finish === 1'b1 && fin_prev === 1'b0);
      fin_prev = finish;
      if (fire) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got state %0d expected no event", state);
        end else begin
          e = exp_q.pop_front();
          check(e.tag, "state",     32'(state),                 32'(e.st));
          check(e.tag, "error_num", 32'(error_num),             32'(e.err));
          check(e.tag, "duration",  32'(duration),              32'(e.dur));
          check(e.tag, "flush0",    32'(flush_cnt[0 +: CNTW]),  32'(e.f0));
          check(e.tag, "flush1",    32'(flush_cnt[CNTW +: CNTW]), 32'(e.f1));
          check(e.tag, "stall_cnt", 32'(stall_cnt),             32'(e.sc));
          check(e.tag, "finish",    32'(finish),                32'(e.fin));
          check(e.tag, "timeout",   32'(timeout),               32'(e.tmo));
        end
      end
    end
  end

  task automatic drive(input logic st, input logic fl, input logic bt,
                       input logic we, input logic [29:0] a, input logic [31:0] d);
    stall   = st;
    flush   = fl;
    br_type = bt;
    wen     = we;
    addr    = a;
    data    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we = 1'b0; start = 1'b0; flush = 1'b0; stall = 1'b0;
    br_type = '0; wen = 1'b0; addr = '0; data = '0;
  endtask

  task automatic probe_exp(input exp_t e);
    exp_q.push_back(e);
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic load(input int idx, input logic [29:0] a, input logic [31:0] d,
                      input logic with_start);
    cfg_we   = 1'b1;
    cfg_idx  = IDXW'(idx);
    cfg_addr = a;
    cfg_data = d;
    start    = with_start;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    start  = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic good_writes();
    for (int i = 0; i < N_CHECK; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 30'(16 + i), 32'(i + 1));
    end
    idle_inputs();
  endtask

  task automatic wait_finish(input int tag, input int budget);
    int n;
    n = 0;
    while (finish !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (finish !== 1'b1) begin
      errors++;
      $display("FAIL t%0d finish_wait got finish=%0b expected 1 within %0d cycles",
               tag, finish, budget);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no end of stimulus expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    probe  = 1'b0;
    cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    idle_inputs();
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    probe_exp(mk(1, ST_IDLE, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    rst_n = 1'b1;

    // Load golden table; start coincident with the last write must be ignored.
    for (int i = 0; i < N_CHECK - 1; i++) load(i, 30'(16 + i), 32'(i + 1), 1'b0);
    load(N_CHECK - 1, 30'(16 + N_CHECK - 1), 32'(N_CHECK), 1'b1);
    probe_exp(mk(2, ST_IDLE, 0, 0, 0, 0, 0, 1'b0, 1'b0));

    // All-correct run.
    start_pulse();
    exp_q.push_back(mk(3, ST_DONE, 0, 4, 0, 0, 0, 1'b1, 1'b0));
    good_writes();
    wait_finish(3, 5);
    // DONE freezes counters and ignores start and further writes.
    start_pulse();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 30'h1, 32'h1);
    idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    probe_exp(mk(4, ST_DONE, 0, 4, 0, 0, 0, 1'b1, 1'b0));

    // Two mismatches.
    do_reset();
    start_pulse();
    exp_q.push_back(mk(5, ST_DONE, 2, 4, 0, 0, 0, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 30'h10, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 30'h11, 32'hFF);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 30'h12, 32'h3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 30'h20, 32'h4);
    idle_inputs();
    wait_finish(5, 5);

    // Stalled write held 3 cycles, flushes by type, cfg write attempted mid-run.
    do_reset();
    start_pulse();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 30'h10, 32'h1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 30'h10, 32'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 30'h10, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 30'h10, 32'h1);
    probe_exp(mk(6, ST_RUN, 0, 4, 0, 0, 3, 1'b0, 1'b0));
    exp_q.push_back(mk(7, ST_DONE, 0, 14, 5, 3, 3, 1'b1, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b1, 30'h11, 32'h2);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 30'h0, 32'h0);
    cfg_we = 1'b1; cfg_idx = '0; cfg_addr = 30'h3FF; cfg_data = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 30'h12, 32'h3);
    cfg_we = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 30'h13, 32'h4);
    idle_inputs();
    wait_finish(7, 5);

    // Final compare on the timeout edge: DONE wins.
    do_reset();
    start_pulse();
    exp_q.push_back(mk(8, ST_DONE, 0, 20, 0, 0, 0, 1'b1, 1'b0));
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    good_writes();
    wait_finish(8, 5);

    // Timeout with no writes; later start has no effect.
    do_reset();
    start_pulse();
    exp_q.push_back(mk(9, ST_TMO, 0, 20, 0, 0, 0, 1'b1, 1'b1));
    wait_finish(9, 30);
    start_pulse();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    probe_exp(mk(10, ST_TMO, 0, 20, 0, 0, 0, 1'b1, 1'b1));

    // Asynchronous reset mid-run; golden table retained.
    do_reset();
    start_pulse();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 30'h10, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 30'h11, 32'h2);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    probe_exp(mk(11, ST_IDLE, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    rst_n = 1'b1;
    start_pulse();
    exp_q.push_back(mk(12, ST_DONE, 0, 4, 0, 0, 0, 1'b1, 1'b0));
    good_writes();
    wait_finish(12, 5);

    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL t%0d pending got no output expected state %0d", e.tag, e.st);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_perf_monitor.md
Name: branch_perf_monitor

Overview:
Parametrised, synthesizable run monitor for the branch-prediction pipeline bench. It checks the CHIP's committed data-cache writes in order against a loadable golden table, counts run cycles, stall cycles and per-branch-type flushes, and signals finish or timeout. It sits beside CHIP in every configuration: noBP, lv1hash, lv1cach, lv2glo and lv2loc. It generalises the fixed TestBed to N checks, T branch types, counter widths and a hardware timeout.

Parameters:
N_CHECK, 16, number of golden (addr, data) entries; must be >= 1
IDXW, 4, golden index width; must satisfy 2^IDXW >= N_CHECK
NUM_TYPES, 2, number of branch-type channels; must be >= 2
TYPEW, 1, br_type width; must satisfy 2^TYPEW >= NUM_TYPES
CNTW, 16, width of each flush counter, the stall counter and duration
ERRW, 8, error counter width
TIMEOUT_CYC, 50000, number of RUN cycles before timeout; must be < 2^CNTW

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
cfg_we  in  1  golden table write strobe
cfg_idx  in  IDXW  golden entry index
cfg_addr  in  30  golden word address
cfg_data  in  32  golden write data
start  in  1  one-cycle run start
flush  in  1  pipeline instruction flush
stall  in  1  memory stall
br_type  in  TYPEW  branch type of the current flush
wen  in  1  DCACHE write enable
addr  in  30  DCACHE word address
data  in  32  DCACHE write data
error_num  out  ERRW  mismatch count
duration  out  CNTW  RUN cycle count
flush_cnt  out  NUM_TYPES*CNTW  per-type flush counts; type k occupies bits [k*CNTW +: CNTW]
stall_cnt  out  CNTW  stalled RUN cycles
state  out  2  current state: IDLE=0, RUN=1, DONE=2, TIMEOUT=3
finish  out  1  high in DONE or TIMEOUT
timeout  out  1  high in TIMEOUT only

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. All counters, error_num, the check pointer, finish and timeout go to 0. Golden table contents are not reset.
- IDLE:
  - cfg_we=1 writes golden[cfg_idx] <= {cfg_addr, cfg_data} at the clock edge.
  - Writes with cfg_idx >= N_CHECK are ignored.
  - start=1 with cfg_we=0 moves to RUN on the next edge, clearing pointer and all counters.
  - start=1 together with cfg_we=1: the write is performed and start is ignored.
- cfg_we is ignored outside IDLE.
- RUN, every cycle:
  - duration increments, saturating at all-ones.
  - If stall=1: stall_cnt increments (saturating). flush and wen are ignored that cycle, because a stalled write is not committed.
  - If stall=0 and flush=1: flush_cnt[br_type] increments (saturating). br_type >= NUM_TYPES is ignored.
  - If stall=0 and wen=1: compare {addr, data} with golden[ptr]. On mismatch, error_num increments, saturating at 2^ERRW-1. Then ptr increments.
  - If that compare used ptr=N_CHECK-1: next state is DONE, and the final compare's error is included.
- Timeout: in RUN, when duration equals TIMEOUT_CYC-1 at a clock edge with no final compare, next state is TIMEOUT.
- Priority: if the final compare and the timeout condition fall on the same edge, DONE wins.
- DONE and TIMEOUT are sticky until reset. In both, counters and error_num freeze, finish=1, and the state ignores all inputs including start.
- Output timing:
  - All outputs are registered.
  - Counter values become visible the cycle after the triggering edge.
  - finish rises the cycle after the final compare edge.
- Flush and wen in the same unstalled cycle are both processed.

Test Plan:
- Load N_CHECK=4 entries ({0x10, 1}, {0x11, 2}, {0x12, 3}, {0x13, 4}), pulse start, drive those 4 unstalled writes -> error_num=0, state=DONE, finish=1 one cycle after the 4th write, duration equals the RUN cycle count.
- Same run with the 2nd write data=0xFF and the 4th address=0x20 -> error_num=2, DONE, ptr finished at 4.
- Write held with stall=1 for 3 cycles, then stall=0 for 1 cycle -> exactly one compare, stall_cnt=3.
- Flushes: 5 with br_type=0, 3 with br_type=1, 2 with stall=1 -> flush_cnt[0]=5, flush_cnt[1]=3.
- TIMEOUT_CYC=20 with no writes -> state=TIMEOUT, timeout=1, finish=1, duration=20 frozen; a later start has no effect.
- rst_n pulsed low mid-RUN after 2 writes -> immediate IDLE, all outputs 0. Golden table retained: a new start plus the 4 correct writes gives error_num=0.
